ahb_arb2: RTL and testbench

AHB_ARB2 -- requirements
Module: ahb_arb2

---
 rtl/ahb_arb2_pkg.sv | 23 ++
 rtl/ahb_arb2_rr.sv | 29 ++
 rtl/ahb_arb2.sv | 159 +++++++++++++++
 tb/tb_ahb_arb2.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ahb_arb2_pkg.sv
// Shared types and constants for the two-requester AHB arbiter.
// The timeout feature is enabled by defining AHB_ARB2_TIMEOUT_EN.
package ahb_arb2_pkg;

  localparam int DEF_DW          = 32;
  localparam int DEF_AW          = 32;
  localparam int DEF_TIMEOUT_CYC = 16;

  localparam logic HTRANS_IDLE   = 1'b0;
  localparam logic HTRANS_NONSEQ = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // Plain-vector encodings of the state enum for the FSM register
  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_ADDR = 2'(ST_ADDR);
  localparam logic [1:0] S_DATA = 2'(ST_DATA);

endpackage

// File: rtl/ahb_arb2_rr.sv
// Two-way round-robin selector: ptr names the requester that wins a tie,
// which after every grant becomes the requester that was not granted.
module ahb_arb2_rr (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       ptr
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      ptr <= 1'b0;
    else if (advance && (gnt != 2'b00))
      ptr <= ~gnt[1];
  end

endmodule

// File: rtl/ahb_arb2.sv
// Two-requester single-transfer AHB master arbiter (IDLE -> ADDR -> DATA).
// Define AHB_ARB2_TIMEOUT_EN to add a data-phase wait timeout with ERRn.
module ahb_arb2
  import ahb_arb2_pkg::*;
#(
  parameter int DW          = DEF_DW,
  parameter int AW          = DEF_AW,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic          WRITE0,
  input  logic          WRITE1,
  input  logic [AW-1:0] ADDR0,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WDATA0,
  input  logic [DW-1:0] WDATA1,
  output logic          ACK0,
  output logic          ACK1,
  output logic [DW-1:0] RDATA0,
  output logic [DW-1:0] RDATA1,
  output logic          ERR0,
  output logic          ERR1,
  output logic          HSEL,
  output logic          HTRANS,
  output logic          HWRITE,
  output logic [AW-1:0] HADDR,
  output logic [DW-1:0] HWDATA,
  output logic          HREADY,
  input  logic          HREADY_RESP,
  input  logic [DW-1:0] HRDATA
);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [1:0]    req_eff;
  logic [1:0]    rr_gnt;
  logic          rr_ptr;
  logic          rr_adv;
  logic          owner;
  logic          done_ok;
  logic          to_hit;
  logic          finish;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;

  // A requester's ACK cycle is not a request, so nothing is granted then
  assign req_eff = (ACK0 || ACK1) ? 2'b00 : {REQ1, REQ0};
  assign rr_adv  = (state == S_IDLE) && (req_eff != 2'b00);

  ahb_arb2_rr u_rr (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .req     (req_eff),
    .advance (rr_adv),
    .gnt     (rr_gnt),
    .ptr     (rr_ptr)
  );

  // The pointer always favours the other requester after a grant, so the
  // owner of the transfer in flight is simply its complement.
  assign owner   = ~rr_ptr;
  assign done_ok = (state == S_DATA) && HREADY_RESP;
  assign finish  = done_ok || to_hit;

`ifdef AHB_ARB2_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] to_cnt;
  logic          err0_q;
  logic          err1_q;

  assign to_hit = (state == S_DATA) && !HREADY_RESP &&
                  (to_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      to_cnt <= '0;
    else if ((state == S_DATA) && !HREADY_RESP && !to_hit)
      to_cnt <= to_cnt + CW'(1);
    else
      to_cnt <= '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err0_q <= 1'b0;
      err1_q <= 1'b0;
    end else begin
      err0_q <= to_hit && !owner;
      err1_q <= to_hit && owner;
    end
  end

  assign ERR0 = err0_q;
  assign ERR1 = err1_q;
`else
  assign to_hit = 1'b0;
  assign ERR0   = 1'b0;
  assign ERR1   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (rr_adv)      state_nxt = S_ADDR;
      S_ADDR:  if (HREADY_RESP) state_nxt = S_DATA;
      S_DATA:  if (finish)      state_nxt = S_IDLE;
      default:                  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Command is captured at grant so a requester dropping REQ cannot disturb it
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (rr_adv) begin
      cmd_write <= rr_gnt[1] ? WRITE1 : WRITE0;
      cmd_addr  <= rr_gnt[1] ? ADDR1  : ADDR0;
      cmd_wdata <= rr_gnt[1] ? WDATA1 : WDATA0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ACK0   <= 1'b0;
      ACK1   <= 1'b0;
      RDATA0 <= '0;
      RDATA1 <= '0;
    end else begin
      ACK0 <= finish && !owner;
      ACK1 <= finish && owner;
      if (finish && !owner)
        RDATA0 <= (to_hit || cmd_write) ? '0 : HRDATA;
      if (finish && owner)
        RDATA1 <= (to_hit || cmd_write) ? '0 : HRDATA;
    end
  end

  assign HSEL   = (state == S_ADDR);
  assign HTRANS = HSEL ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWRITE = cmd_write;
  assign HADDR  = cmd_addr;
  assign HWDATA = cmd_wdata;
  assign HREADY = HREADY_RESP;

endmodule

// File: tb/tb_ahb_arb2.sv
// Directed self-checking bench for ahb_arb2; expectations follow the
// AHB_ARB2_TIMEOUT_EN setting of the build.
module tb_ahb_arb2;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REQ0, REQ1, WRITE0, WRITE1;
  logic [31:0] ADDR0, ADDR1, WDATA0, WDATA1;
  logic        ACK0, ACK1, ERR0, ERR1;
  logic [31:0] RDATA0, RDATA1;
  logic        HSEL, HTRANS, HWRITE, HREADY, HREADY_RESP;
  logic [31:0] HADDR, HWDATA, HRDATA;

  int vectors     = 0;
  int miscompares = 0;
  int ack_cnt;
  int owner;

  always #5 CLK = ~CLK;

  ahb_arb2 #(.DW(32), .AW(32), .TIMEOUT_CYC(16)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0(REQ0), .REQ1(REQ1), .WRITE0(WRITE0), .WRITE1(WRITE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .ACK0(ACK0), .ACK1(ACK1), .RDATA0(RDATA0), .RDATA1(RDATA1),
    .ERR0(ERR0), .ERR1(ERR1),
    .HSEL(HSEL), .HTRANS(HTRANS), .HWRITE(HWRITE), .HADDR(HADDR),
    .HWDATA(HWDATA), .HREADY(HREADY), .HREADY_RESP(HREADY_RESP),
    .HRDATA(HRDATA)
  );

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    RST_N = 1'b0;
    REQ0 = 0; REQ1 = 0; WRITE0 = 0; WRITE1 = 0;
    ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
    HREADY_RESP = 1'b1; HRDATA = '0;
    step(2);
    check_output("rst_hsel",   {31'd0, HSEL},   0);
    check_output("rst_htrans", {31'd0, HTRANS}, 0);
    check_output("rst_hwrite", {31'd0, HWRITE}, 0);
    check_output("rst_haddr",  HADDR,  0);
    check_output("rst_hwdata", HWDATA, 0);
    check_output("rst_acks",   {28'd0, ACK1, ACK0, ERR1, ERR0}, 0);
    check_output("rst_rdata0", RDATA0, 0);
    check_output("rst_rdata1", RDATA1, 0);
    RST_N = 1'b1;

    $display("[TB] both requesters held, four transfers");
    ADDR0 = 32'h100; ADDR1 = 32'h200;
    REQ0 = 1; REQ1 = 1;
    for (int c = 1; c <= 16; c++) begin
      step(1);
      owner = ((c - 1) / 4) % 2;
      case ((c - 1) % 4)
        0: begin
          check_output("rr_hsel",  {31'd0, HSEL}, 1);
          check_output("rr_haddr", HADDR, (owner == 1) ? 32'h200 : 32'h100);
        end
        1: HRDATA = 32'hC0DE_0000 | 32'((c - 1) / 4);
        2: begin
          check_output("rr_ack", {30'd0, ACK1, ACK0}, (owner == 1) ? 2 : 1);
          check_output("rr_rdata", (owner == 1) ? RDATA1 : RDATA0,
                       32'hC0DE_0000 | 32'((c - 1) / 4));
          if (c == 15) begin REQ0 = 0; REQ1 = 0; end
        end
        default: check_output("rr_noack", {30'd0, ACK1, ACK0}, 0);
      endcase
    end

    $display("[TB] requester 0 zero-wait write");
    REQ0 = 1; WRITE0 = 1; ADDR0 = 32'h10; WDATA0 = 32'hA5A5_A5A5;
    step(1);
    check_output("wr_addr_ctl", {29'd0, HSEL, HTRANS, HWRITE}, 3'b111);
    check_output("wr_haddr", HADDR, 32'h10);
    check_output("wr_early_ack", {31'd0, ACK0}, 0);
    step(1);
    check_output("wr_data_ctl", {30'd0, HSEL, HTRANS}, 0);
    check_output("wr_hwdata", HWDATA, 32'hA5A5_A5A5);
    step(1);
    check_output("wr_ack", {29'd0, ACK1, ACK0, ERR0}, 3'b010);
    check_output("wr_rdata0", RDATA0, 0);
    REQ0 = 0;
    step(1);
    check_output("wr_ack_pulse", {31'd0, ACK0}, 0);

    $display("[TB] requester 0 drops request after grant");
    REQ0 = 1; WRITE0 = 0; ADDR0 = 32'h44; HRDATA = 32'h1234_5678;
    step(1);
    check_output("drop_haddr", HADDR, 32'h44);
    REQ0 = 0; ADDR0 = 32'hFFF0;
    step(2);
    check_output("drop_ack", {31'd0, ACK0}, 1);
    check_output("drop_rdata0", RDATA0, 32'h1234_5678);
    ack_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      step(1);
      ack_cnt += int'(ACK0) + int'(HSEL);
    end
    check_output("drop_single_ack", 32'(ack_cnt), 0);

    $display("[TB] requester 1 read with five wait states");
    REQ1 = 1; WRITE1 = 0; ADDR1 = 32'h20; HRDATA = '0;
    step(1);
    check_output("ws_haddr", HADDR, 32'h20);
    check_output("ws_hwrite", {31'd0, HWRITE}, 0);
    step(1);
    HREADY_RESP = 0;
    check_output("ws_hready", {31'd0, HREADY}, 0);
    ack_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      step(1);
      ack_cnt += int'(ACK1) + int'(HSEL);
    end
    check_output("ws_no_early_ack", 32'(ack_cnt), 0);
    HREADY_RESP = 1; HRDATA = 32'hDEAD_BEEF;
    step(1);
    check_output("ws_ack1", {30'd0, ACK1, ACK0}, 2'b10);
    check_output("ws_rdata1", RDATA1, 32'hDEAD_BEEF);
    REQ1 = 0; HRDATA = 32'h0;
    step(1);
    check_output("ws_rdata1_hold", RDATA1, 32'hDEAD_BEEF);
    check_output("ws_ack1_pulse", {31'd0, ACK1}, 0);

    $display("[TB] reset during data phase");
    REQ0 = 1; WRITE0 = 1; ADDR0 = 32'h30; WDATA0 = 32'h55;
    step(2);
    check_output("rd_data_hwdata", HWDATA, 32'h55);
    HREADY_RESP = 0;
    RST_N = 0;
    #1;
    check_output("rd_ctl_zero", {29'd0, HSEL, HTRANS, HWRITE}, 0);
    check_output("rd_haddr_zero", HADDR, 0);
    check_output("rd_hwdata_zero", HWDATA, 0);
    check_output("rd_rdata1_zero", RDATA1, 0);
    ack_cnt = 0;
    HREADY_RESP = 1;
    WRITE0 = 0; ADDR0 = 32'h40; WRITE1 = 0; ADDR1 = 32'h50;
    REQ1 = 1; HRDATA = 32'h77;
    for (int c = 0; c < 3; c++) begin
      step(1);
      ack_cnt += int'(ACK0) + int'(ACK1);
    end
    check_output("rd_no_ack", 32'(ack_cnt), 0);
    RST_N = 1;
    step(1);
    check_output("rd_first_haddr", HADDR, 32'h40);
    step(2);
    check_output("rd_ack0", {30'd0, ACK1, ACK0}, 2'b01);
    check_output("rd_rdata0", RDATA0, 32'h77);
    REQ0 = 0;
    step(2);
    check_output("rd_second_haddr", HADDR, 32'h50);
    step(2);
    check_output("rd_ack1", {30'd0, ACK1, ACK0}, 2'b10);
    REQ1 = 0;
    step(1);

    $display("[TB] slave stuck not ready");
    REQ0 = 1; WRITE0 = 0; ADDR0 = 32'h60;
    step(2);
    HREADY_RESP = 0;
    ack_cnt = 0;
`ifdef AHB_ARB2_TIMEOUT_EN
    for (int c = 0; c < 15; c++) begin
      step(1);
      ack_cnt += int'(ACK0);
    end
    check_output("to_no_early_ack", 32'(ack_cnt), 0);
    step(1);
    check_output("to_ack_err", {30'd0, ACK0, ERR0}, 2'b11);
    check_output("to_rdata0", RDATA0, 0);
    REQ0 = 0;
    step(1);
    check_output("to_ack_pulse", {30'd0, ACK0, ERR0}, 0);
`else
    for (int c = 0; c < 100; c++) begin
      step(1);
      ack_cnt += int'(ACK0) + int'(ERR0);
    end
    check_output("to_no_ack", 32'(ack_cnt), 0);
    REQ0 = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
